decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/cpu_types_pkg.sv | 119 +++++++++++
 rtl/decode_stage_if.sv | 24 ++
 rtl/register_file.sv | 44 ++++
 rtl/decode_stage.sv | 105 ++++++++++
 tb/tb_decode_stage.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - Shared decode types, opcode/funct encodings and decode helpers.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;
    typedef logic [31:0]      word_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
        OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a,
        OP_SLTIU = 6'h0b, OP_ANDI  = 6'h0c, OP_ORI   = 6'h0d, OP_XORI = 6'h0e,
        OP_LUI   = 6'h0f, OP_LW    = 6'h23, OP_SW    = 6'h2b
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR  = 6'h08, FN_ADD = 6'h20,
        FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
        FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2a,
        FN_SLTU = 6'h2b
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef struct packed {
        aluop_t aluop;
        logic   regdst;
        logic   alusrc;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   regwrite;
        logic   beq;
        logic   bne;
        logic   jump;
        logic   link;
        logic   jr;
        logic   illegal;
    } control_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t npc;
    } fetch_latch_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } cpu_tracker_t;

    typedef struct packed {
        logic     valid;
        word_t    pc;
        word_t    npc;
        opcode_t  opcode;
        funct_t   funct;
        regbits_t rs;
        regbits_t rt;
        regbits_t rd;
        logic [4:0] shamt;
        word_t    rdat1;
        word_t    rdat2;
        word_t    imm_ext;
        control_t ctrl;
    } decode_latch_t;

    function automatic word_t ext_imm(input opcode_t op, input logic [15:0] imm);
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: return {16'h0000, imm};
            OP_LUI:                   return {imm, 16'h0000};
            default:                  return {{16{imm[15]}}, imm};
        endcase
    endfunction

    // Anything not recognised leaves an all-zero (nop) bundle with only illegal set.
    function automatic control_t decode_ctrl(input opcode_t op, input funct_t fn);
        control_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                case (fn)
                    FN_SLL:          c.aluop = ALU_SLL;
                    FN_SRL:          c.aluop = ALU_SRL;
                    FN_JR:           begin c.jr = 1'b1; c.regwrite = 1'b0; end
                    FN_ADD, FN_ADDU: c.aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: c.aluop = ALU_SUB;
                    FN_AND:          c.aluop = ALU_AND;
                    FN_OR:           c.aluop = ALU_OR;
                    FN_XOR:          c.aluop = ALU_XOR;
                    FN_NOR:          c.aluop = ALU_NOR;
                    FN_SLT:          c.aluop = ALU_SLT;
                    FN_SLTU:         c.aluop = ALU_SLTU;
                    default:         begin c = '0; c.illegal = 1'b1; end
                endcase
            end
            OP_J:    c.jump = 1'b1;
            OP_JAL:  begin c.jump = 1'b1; c.link = 1'b1; c.regwrite = 1'b1; end
            OP_BEQ:  begin c.beq = 1'b1; c.aluop = ALU_SUB; end
            OP_BNE:  begin c.bne = 1'b1; c.aluop = ALU_SUB; end
            OP_ADDI, OP_ADDIU, OP_LUI: begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = ALU_ADD; end
            OP_SLTI:  begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = ALU_SLT; end
            OP_SLTIU: begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = ALU_SLTU; end
            OP_ANDI:  begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = ALU_AND; end
            OP_ORI:   begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = ALU_OR; end
            OP_XORI:  begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = ALU_XOR; end
            OP_LW:    begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.memread = 1'b1; c.memtoreg = 1'b1; c.aluop = ALU_ADD; end
            OP_SW:    begin c.alusrc = 1'b1; c.memwrite = 1'b1; c.aluop = ALU_ADD; end
            default:  c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - Port grouping for decode_stage; modport ds is the stage's view.
interface decode_stage_if;
    import cpu_types_pkg::*;

    fetch_latch_t  in;
    cpu_tracker_t  track_in;
    logic          ihit;
    logic          stall;
    logic          flush;
    logic          ex_memread;
    regbits_t      ex_rt;
    logic          wb_wen;
    regbits_t      wb_wsel;
    word_t         wb_wdat;
    decode_latch_t out;
    cpu_tracker_t  track_out;
    logic          hazard_stall;

    modport ds (
        input  in, track_in, ihit, stall, flush, ex_memread, ex_rt,
        input  wb_wen, wb_wsel, wb_wdat,
        output out, track_out, hazard_stall
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - NREGS x 32 register file, r0 hardwired to zero.
// DECODE_BYPASS_EN: a same-cycle write is forwarded to the read ports (write-first).
module register_file #(
    parameter int  NREGS = 32,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wen,
    input  logic [IDX_W-1:0] wsel,
    input  logic [31:0]      wdat,
    input  logic [IDX_W-1:0] rsel1,
    input  logic [IDX_W-1:0] rsel2,
    output logic [31:0]      rdat1,
    output logic [31:0]      rdat2
);

    logic [NREGS-1:0][31:0] regs_q;
    logic [NREGS-1:0][31:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (wen && (wsel != '0)) begin
            regs_d[wsel] = wdat;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef DECODE_BYPASS_EN
    assign rdat1 = (rsel1 == '0) ? '0 : (wen && (wsel == rsel1)) ? wdat : regs_q[rsel1];
    assign rdat2 = (rsel2 == '0) ? '0 : (wen && (wsel == rsel2)) ? wdat : regs_q[rsel2];
`else
    assign rdat1 = (rsel1 == '0) ? '0 : regs_q[rsel1];
    assign rdat2 = (rsel2 == '0) ? '0 : regs_q[rsel2];
`endif

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - Instruction decode latch with load-use hazard detection.
// Register file read bypass is selected by DECODE_BYPASS_EN.
module decode_stage
    import cpu_types_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  fetch_latch_t  in,
    input  cpu_tracker_t  track_in,
    input  logic          ihit,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_memread,
    input  regbits_t      ex_rt,
    input  logic          wb_wen,
    input  regbits_t      wb_wsel,
    input  word_t         wb_wdat,
    output decode_latch_t out,
    output cpu_tracker_t  track_out,
    output logic          hazard_stall
);

    localparam int IDX_W = $clog2(NREGS);

    decode_latch_t out_q, out_d, load_val;
    cpu_tracker_t  track_q, track_d;
    opcode_t       op;
    funct_t        fn;
    regbits_t      rs, rt;
    word_t         rf_rdat1, rf_rdat2;
    logic          reads_rt;
    logic          hazard;

    assign op = opcode_t'(in.instr[31:26]);
    assign fn = funct_t'(in.instr[5:0]);
    assign rs = in.instr[25:21];
    assign rt = in.instr[20:16];

    register_file #(.NREGS(NREGS)) u_rf (
        .CLK   (CLK),
        .RST   (RST),
        .wen   (wb_wen),
        .wsel  (wb_wsel[IDX_W-1:0]),
        .wdat  (wb_wdat),
        .rsel1 (rs[IDX_W-1:0]),
        .rsel2 (rt[IDX_W-1:0]),
        .rdat1 (rf_rdat1),
        .rdat2 (rf_rdat2)
    );

    // Only R-type, branches and stores consume rt as a source operand.
    always_comb begin
        reads_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
        hazard   = !flush && ex_memread && (ex_rt != '0) &&
                   ((ex_rt == rs) || (reads_rt && (ex_rt == rt)));
    end

    always_comb begin
        load_val         = '0;
        load_val.valid   = 1'b1;
        load_val.pc      = in.pc;
        load_val.npc     = in.npc;
        load_val.opcode  = op;
        load_val.funct   = fn;
        load_val.rs      = rs;
        load_val.rt      = rt;
        load_val.rd      = in.instr[15:11];
        load_val.shamt   = in.instr[10:6];
        load_val.rdat1   = rf_rdat1;
        load_val.rdat2   = rf_rdat2;
        load_val.imm_ext = ext_imm(op, in.instr[15:0]);
        load_val.ctrl    = decode_ctrl(op, fn);
    end

    always_comb begin
        out_d   = out_q;
        track_d = track_q;
        if (!stall) begin
            if (flush || hazard) begin
                out_d   = '0;
                track_d = '0;
            end else if (ihit) begin
                out_d   = load_val;
                track_d = track_in;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_q   <= '0;
            track_q <= '0;
        end else begin
            out_q   <= out_d;
            track_q <= track_d;
        end
    end

    assign out          = out_q;
    assign track_out    = track_q;
    assign hazard_stall = hazard;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - Scoreboard bench for decode_stage.
module tb_decode_stage;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        illegal;
        logic        regwrite;
        logic [63:0] trk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    decode_stage_if dif ();

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];
    exp_t last;
    logic [31:0] rf [32];
    logic [31:0] pc_cnt = 32'h0000_0100;

    always #5 clk = ~clk;

    decode_stage dut (
        .CLK          (clk),
        .RST          (rst),
        .in           (dif.in),
        .track_in     (dif.track_in),
        .ihit         (dif.ihit),
        .stall        (dif.stall),
        .flush        (dif.flush),
        .ex_memread   (dif.ex_memread),
        .ex_rt        (dif.ex_rt),
        .wb_wen       (dif.wb_wen),
        .wb_wsel      (dif.wb_wsel),
        .wb_wdat      (dif.wb_wdat),
        .out          (dif.out),
        .track_out    (dif.track_out),
        .hazard_stall (dif.hazard_stall)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [5:0] f);
        return {6'h00, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
        return {o, s, t, imm};
    endfunction

    function automatic logic [31:0] sx(input logic [31:0] i);
        return {{16{i[15]}}, i[15:0]};
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
`ifdef DECODE_BYPASS_EN
        if (dif.wb_wen && (dif.wb_wsel == r)) return dif.wb_wdat;
`endif
        return rf[r];
    endfunction

    function automatic exp_t exp_load(input logic [31:0] imm, input logic ill, input logic rw);
        exp_t e;
        logic [31:0] i;
        i          = dif.in.instr;
        e.valid    = 1'b1;
        e.pc       = dif.in.pc;
        e.rdat1    = model_rd(i[25:21]);
        e.rdat2    = model_rd(i[20:16]);
        e.imm      = imm;
        e.rs       = i[25:21];
        e.rt       = i[20:16];
        e.rd       = i[15:11];
        e.illegal  = ill;
        e.regwrite = rw;
        e.trk      = {dif.in.pc, i};
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t g;
        g.valid    = dif.out.valid;
        g.pc       = dif.out.pc;
        g.rdat1    = dif.out.rdat1;
        g.rdat2    = dif.out.rdat2;
        g.imm      = dif.out.imm_ext;
        g.rs       = dif.out.rs;
        g.rt       = dif.out.rt;
        g.rd       = dif.out.rd;
        g.illegal  = dif.out.ctrl.illegal;
        g.regwrite = dif.out.ctrl.regwrite;
        g.trk      = {dif.track_out.pc, dif.track_out.instr};
        return g;
    endfunction

    task automatic drive(input logic [31:0] i);
        dif.in.instr       = i;
        dif.in.pc          = pc_cnt;
        dif.in.npc         = pc_cnt + 32'd4;
        dif.track_in.pc    = pc_cnt;
        dif.track_in.instr = i;
        pc_cnt             = pc_cnt + 32'd4;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick(input string tag, input logic exp_haz, input exp_t e);
        exp_t want;
        #1;
        check({tag, "_haz"}, 256'(dif.hazard_stall), 256'(exp_haz));
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 256'(1), 256'(0));
        end else begin
            want = sb.pop_front();
            check(tag, 256'(observe()), 256'(want));
            last = want;
        end
        if (dif.wb_wen && (dif.wb_wsel != 5'd0)) rf[dif.wb_wsel] = dif.wb_wdat;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [4:0]  wsel_t [5];
        logic [31:0] wdat_t [5];
        logic [31:0] i_add;
        wsel_t = '{5'd8, 5'd4, 5'd3, 5'd5, 5'd7};
        wdat_t = '{32'h0000_00AA, 32'h44, 32'h33, 32'h55, 32'h77};
        for (int k = 0; k < 32; k++) rf[k] = 32'h0;
        last = '0;
        dif.ihit = 0; dif.stall = 0; dif.flush = 0; dif.ex_memread = 0; dif.ex_rt = '0;
        dif.wb_wen = 0; dif.wb_wsel = '0; dif.wb_wdat = '0;
        drive(32'h0);

        #2;
        check("reset_out", 256'(dif.out), 256'(0));
        check("reset_track", 256'(dif.track_out), 256'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            dif.wb_wen = 1; dif.wb_wsel = wsel_t[k]; dif.wb_wdat = wdat_t[k];
            tick("wb_write_hold", 1'b0, last);
        end
        dif.wb_wen = 0;

        dif.ihit = 1;
        drive(rtype(5'd8, 5'd0, 5'd9, 6'h21));
        tick("addu_r8", 1'b0, exp_load(sx(dif.in.instr), 1'b0, 1'b1));

        i_add = rtype(5'd4, 5'd3, 5'd2, 6'h20);
        dif.ex_memread = 1; dif.ex_rt = 5'd4;
        drive(i_add);
        tick("hazard_rs_bubble", 1'b1, '0);
        dif.ex_memread = 0;
        tick("hazard_reissue", 1'b0, exp_load(sx(i_add), 1'b0, 1'b1));

        dif.ex_memread = 1; dif.ex_rt = 5'd3;
        drive(itype(6'h2b, 5'd4, 5'd3, 16'h0010));
        tick("hazard_sw_rt", 1'b1, '0);
        drive(itype(6'h08, 5'd4, 5'd3, 16'h0001));
        tick("addi_rt_nohaz", 1'b0, exp_load(32'h1, 1'b0, 1'b1));
        dif.ex_rt = 5'd0;
        drive(rtype(5'd0, 5'd0, 5'd9, 6'h21));
        tick("ex_rt_zero", 1'b0, exp_load(sx(dif.in.instr), 1'b0, 1'b1));

        dif.ex_rt = 5'd4; dif.flush = 1;
        drive(i_add);
        tick("flush_bubble", 1'b0, '0);
        check("flush_all_zero", 256'(dif.out), 256'(0));
        dif.flush = 0; dif.ex_memread = 0;

        drive(rtype(5'd8, 5'd0, 5'd9, 6'h21));
        tick("reload", 1'b0, exp_load(sx(dif.in.instr), 1'b0, 1'b1));
        dif.stall = 1; dif.flush = 1;
        drive(rtype(5'd4, 5'd0, 5'd9, 6'h21));
        tick("stall_flush_hold", 1'b0, last);
        dif.flush = 0;
        tick("stall_ihit_hold", 1'b0, last);
        dif.stall = 0; dif.ihit = 0;
        tick("no_ihit_hold", 1'b0, last);
        dif.ihit = 1;

        drive(itype(6'h0d, 5'd0, 5'd1, 16'h8000));
        tick("ori_zext", 1'b0, exp_load(32'h0000_8000, 1'b0, 1'b1));
        drive(itype(6'h08, 5'd0, 5'd1, 16'h8000));
        tick("addi_sext", 1'b0, exp_load(32'hFFFF_8000, 1'b0, 1'b1));
        drive(itype(6'h0f, 5'd0, 5'd1, 16'h8000));
        tick("lui_upper", 1'b0, exp_load(32'h8000_0000, 1'b0, 1'b1));
        drive(itype(6'h0e, 5'd0, 5'd1, 16'h8000));
        tick("xori_zext", 1'b0, exp_load(32'h0000_8000, 1'b0, 1'b1));
        drive(itype(6'h3f, 5'd1, 5'd2, 16'h1234));
        tick("illegal_op", 1'b0, exp_load(32'h0000_1234, 1'b1, 1'b0));

        dif.wb_wen = 1; dif.wb_wsel = 5'd7; dif.wb_wdat = 32'h0000_1234;
        drive(rtype(5'd7, 5'd0, 5'd1, 6'h21));
`ifdef DECODE_BYPASS_EN
        check("bypass_model", 256'(model_rd(5'd7)), 256'(32'h1234));
`else
        check("bypass_model", 256'(model_rd(5'd7)), 256'(32'h77));
`endif
        tick("same_cycle_r7", 1'b0, exp_load(sx(dif.in.instr), 1'b0, 1'b1));
        dif.wb_wen = 0;
        tick("after_write_r7", 1'b0, exp_load(sx(dif.in.instr), 1'b0, 1'b1));
        dif.wb_wen = 1; dif.wb_wsel = 5'd0; dif.wb_wdat = 32'hDEAD_BEEF;
        drive(rtype(5'd0, 5'd0, 5'd1, 6'h21));
        tick("r0_write_same", 1'b0, exp_load(sx(dif.in.instr), 1'b0, 1'b1));
        dif.wb_wen = 0;
        tick("r0_write_after", 1'b0, exp_load(sx(dif.in.instr), 1'b0, 1'b1));

        drive(rtype(5'd5, 5'd0, 5'd9, 6'h21));
        tick("pre_reset_r5", 1'b0, exp_load(sx(dif.in.instr), 1'b0, 1'b1));
        rst = 1'b1;
        dif.ex_memread = 1; dif.ex_rt = 5'd5;
        #1;
        check("async_reset_out", 256'(dif.out), 256'(0));
        check("async_reset_track", 256'(dif.track_out), 256'(0));
        for (int k = 0; k < 32; k++) rf[k] = 32'h0;
        last = '0;
        @(posedge clk);
        #1;
        check("reset_edge_out", 256'(dif.out), 256'(0));
        @(negedge clk);
        rst = 1'b0; dif.ex_memread = 0;
        drive(rtype(5'd5, 5'd0, 5'd9, 6'h21));
        tick("post_reset_r5", 1'b0, exp_load(sx(dif.in.instr), 1'b0, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
